// File: rtl/tpu_instr_scheduler_if.sv
// Handshake bundle between the host/tpu_core side and the instruction scheduler.
// master = environment (host + core), slave = scheduler.
interface tpu_instr_scheduler_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          enable;
    logic [79:0]   host_instr;
    logic          host_valid;
    logic          host_ready;
    logic [79:0]   instr_port;
    logic          instr_enable;
    logic          busy;
    logic          synchronize;
    logic          sync_done;
    logic [CW-1:0] fifo_count;

    modport master (
        output enable, host_instr, host_valid, busy, synchronize,
        input  host_ready, instr_port, instr_enable, sync_done, fifo_count
    );

    modport slave (
        input  enable, host_instr, host_valid, busy, synchronize,
        output host_ready, instr_port, instr_enable, sync_done, fifo_count
    );
endinterface

// File: rtl/tpu_instr_scheduler.sv
// Instruction FIFO plus issue FSM feeding tpu_core; instr word = {opcode, length, buffer_addr, acc_addr}.
// Optional TPU_SCHED_PERF_EN adds saturating issued_count / stall_count outputs.
module tpu_instr_scheduler #(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] SYNC_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TPU_SCHED_PERF_EN
    output logic [31:0] issued_count,
    output logic [31:0] stall_count,
`endif
    tpu_instr_scheduler_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, HOLD, SYNC_WAIT} state_t;

    state_t        state_q, state_d;
    logic [79:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [79:0]   instr_port_q, instr_port_d;
    logic          instr_enable_q, instr_enable_d;
    logic          sync_done_q, sync_done_d;
    logic          push, pop, empty, full;
    logic [79:0]   head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    // Full is judged on the registered count, so a push is refused even when a pop frees a slot.
    assign push  = bus.host_valid && !full;
    assign head  = mem[rd_ptr_q];

    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        instr_port_d   = instr_port_q;
        instr_enable_d = 1'b0;
        sync_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && !empty && !bus.busy) begin
                    pop            = 1'b1;
                    instr_port_d   = head;
                    instr_enable_d = 1'b1;
                    state_d        = (head[79:72] == SYNC_OPCODE) ? SYNC_WAIT : HOLD;
                end
            end
            HOLD: state_d = IDLE;
            SYNC_WAIT: begin
                if (bus.synchronize) begin
                    sync_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            instr_port_q   <= '0;
            instr_enable_q <= 1'b0;
            sync_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            instr_port_q   <= instr_port_d;
            instr_enable_q <= instr_enable_d;
            sync_done_q    <= sync_done_d;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.host_instr;
        end
    end

    assign bus.host_ready   = !full;
    assign bus.instr_port   = instr_port_q;
    assign bus.instr_enable = instr_enable_q;
    assign bus.sync_done    = sync_done_q;
    assign bus.fifo_count   = count_q;

`ifdef TPU_SCHED_PERF_EN
    logic [31:0] issued_count_q, issued_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        issued_count_d = issued_count_q;
        stall_count_d  = stall_count_q;
        if (instr_enable_q && (issued_count_q != '1)) begin
            issued_count_d = issued_count_q + 32'd1;
        end
        if ((state_q == IDLE) && !empty && (bus.busy || !bus.enable) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_count_q <= '0;
            stall_count_q  <= '0;
        end else begin
            issued_count_q <= issued_count_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign issued_count = issued_count_q;
    assign stall_count  = stall_count_q;
`endif
endmodule

// File: tb/tb_tpu_instr_scheduler.sv
// Bench for tpu_instr_scheduler: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based transaction model.
module tb_tpu_instr_scheduler;
    localparam int DEPTH = 16;
    localparam int FREE = 0, SETTLE = 1, AWAIT_SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tpu_instr_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

`ifdef TPU_SCHED_PERF_EN
    logic [31:0] issued_count, stall_count;
    tpu_instr_scheduler #(.FIFO_DEPTH(DEPTH), .SYNC_OPCODE(8'hFF)) dut (
        .clk(clk), .rst(rst), .issued_count(issued_count), .stall_count(stall_count), .bus(bus));
`else
    tpu_instr_scheduler #(.FIFO_DEPTH(DEPTH), .SYNC_OPCODE(8'hFF)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    int n_checks = 0;
    int n_err    = 0;
    int n_issued = 0;

    // Reference model: queue of accepted instructions and a coarse issue mode.
    logic [79:0] mq[$];
    int          mode   = FREE;
    logic [79:0] m_port = '0;
    bit          m_en   = 0;
    bit          m_sd   = 0;

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(bit en, bit valid, logic [79:0] instr, bit busy, bit sync);
        bus.enable      = en;
        bus.host_valid  = valid;
        bus.host_instr  = instr;
        bus.busy        = busy;
        bus.synchronize = sync;
    endtask

    task automatic model_edge();
        logic [79:0] h;
        bit          iss;
        int          sz;
        h = '0;
        if (!rst) begin
            mq.delete();
            mode = FREE; m_port = '0; m_en = 0; m_sd = 0;
            return;
        end
        sz = mq.size(); iss = 0; m_sd = 0;
        if (mode == FREE && bus.enable && !bus.busy && sz > 0) begin
            h = mq.pop_front();
            iss = 1;
            m_port = h;
        end else if (mode == SETTLE) begin
            mode = FREE;
        end else if (mode == AWAIT_SYNC && bus.synchronize) begin
            mode = FREE;
            m_sd = 1;
        end
        if (iss) mode = (h[79:72] == 8'hFF) ? AWAIT_SYNC : SETTLE;
        if (bus.host_valid && sz != DEPTH) mq.push_back(bus.host_instr);
        m_en = iss;
    endtask

    // One clock: model advances on the edge, DUT outputs are compared 1ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (bus.instr_enable === 1'b1) n_issued++;
        chk("instr_enable", 80'(bus.instr_enable), 80'(m_en));
        chk("instr_port", bus.instr_port, m_port);
        chk("sync_done", 80'(bus.sync_done), 80'(m_sd));
        chk("fifo_count", 80'(bus.fifo_count), 80'(mq.size()));
        chk("host_ready", 80'(bus.host_ready), 80'(mq.size() != DEPTH));
    endtask

    typedef struct {
        bit         en;
        bit         valid;
        logic [7:0] op;
        bit         busy;
        bit         sync;
        bit         x_en;
        logic [7:0] x_op;
        bit         x_sd;
        int         x_cnt;
    } vec_t;

    vec_t vt[14];

    initial begin
        int k, acc, issued_before;
`ifdef TPU_SCHED_PERF_EN
        logic [31:0] stall_before;
`endif
        drive(0, 0, '0, 0, 0);

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("reset_port", bus.instr_port, 80'h0);
        chk("reset_count", 80'(bus.fifo_count), 80'h0);
        rst = 1'b1;

        // Three ordinary instructions, then a sync instruction followed by 8'h09.
        vt[0]  = '{1, 1, 8'h09, 0, 0,  0, 8'h00, 0, 1};
        vt[1]  = '{1, 1, 8'h21, 0, 0,  1, 8'h09, 0, 1};
        vt[2]  = '{1, 1, 8'h99, 0, 0,  0, 8'h09, 0, 2};
        vt[3]  = '{1, 0, 8'h00, 0, 0,  1, 8'h21, 0, 1};
        vt[4]  = '{1, 0, 8'h00, 0, 0,  0, 8'h21, 0, 1};
        vt[5]  = '{1, 0, 8'h00, 0, 0,  1, 8'h99, 0, 0};
        vt[6]  = '{1, 0, 8'h00, 0, 0,  0, 8'h99, 0, 0};
        vt[7]  = '{1, 1, 8'hFF, 0, 0,  0, 8'h99, 0, 1};
        vt[8]  = '{1, 1, 8'h09, 0, 0,  1, 8'hFF, 0, 1};
        vt[9]  = '{1, 0, 8'h00, 0, 0,  0, 8'hFF, 0, 1};
        vt[10] = '{1, 0, 8'h00, 0, 0,  0, 8'hFF, 0, 1};
        vt[11] = '{1, 0, 8'h00, 0, 1,  0, 8'hFF, 1, 1};
        vt[12] = '{1, 0, 8'h00, 0, 0,  1, 8'h09, 0, 0};
        vt[13] = '{1, 0, 8'h00, 0, 0,  0, 8'h09, 0, 0};
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].en, vt[i].valid, {vt[i].op, 32'(i + 1), 24'h00A0B0, 16'(i)}, vt[i].busy, vt[i].sync);
            tick();
            chk($sformatf("vec%0d_en", i), 80'(bus.instr_enable), 80'(vt[i].x_en));
            chk($sformatf("vec%0d_op", i), 80'(bus.instr_port[79:72]), 80'(vt[i].x_op));
            chk($sformatf("vec%0d_sd", i), 80'(bus.sync_done), 80'(vt[i].x_sd));
            chk($sformatf("vec%0d_cnt", i), 80'(bus.fifo_count), 80'(vt[i].x_cnt));
        end

        // Busy stall: five busy cycles with one queued entry, issue right after busy drops.
        drive(1, 1, {8'h21, 72'h5}, 1, 0);
        tick();
`ifdef TPU_SCHED_PERF_EN
        stall_before = stall_count;
`endif
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, '0, 1, 0);
            tick();
            chk("busy_no_issue", 80'(bus.instr_enable), 80'h0);
        end
`ifdef TPU_SCHED_PERF_EN
        chk("stall_count", 80'(stall_count - stall_before), 80'd5);
`endif
        drive(1, 0, '0, 0, 0);
        tick();
        chk("busy_release_issue", 80'(bus.instr_enable), 80'h1);
        chk("busy_release_op", 80'(bus.instr_port[79:72]), 80'h21);
        drive(1, 0, '0, 0, 0);
        tick();

        // Fill with enable low; 17th push must be dropped, then exactly 16 issues.
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 1, {8'h40 + 8'(i), 72'(i)}, 0, 0);
            tick();
        end
        chk("full_count", 80'(bus.fifo_count), 80'd16);
        chk("full_ready", 80'(bus.host_ready), 80'h0);
        issued_before = n_issued;
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, '0, 0, 0);
            tick();
        end
        chk("full_issue_count", 80'(n_issued - issued_before), 80'd16);
        chk("full_drained", 80'(bus.fifo_count), 80'h0);

        // Push+pop at count 16, then 20 more pushes spread over time; model tracks order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, {8'h60, 72'(i)}, 0, 0);
            tick();
        end
        drive(1, 1, {8'h61, 72'hDEAD}, 0, 0);
        tick();
        chk("full_pushpop_count", 80'(bus.fifo_count), 80'd15);
        acc = 0;
        k = 0;
        while (acc < 20 && k < 300) begin
            if ($urandom_range(0, 2) != 0 && bus.host_ready) begin
                drive(1, 1, {8'h70, 72'(acc + 1000)}, 0, 0);
                acc++;
            end else begin
                drive(1, 0, '0, 0, 0);
            end
            tick();
            k++;
        end
        chk("wrap_pushes_done", 80'(acc), 80'd20);
        for (int i = 0; i < 80; i++) begin
            drive(1, 0, '0, 0, 0);
            tick();
        end
        chk("wrap_drained", 80'(bus.fifo_count), 80'h0);

        // Reset while waiting for synchronize with four entries queued.
        drive(0, 1, {8'hFF, 72'h1}, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, {8'h09, 72'(i)}, 0, 0);
            tick();
        end
        drive(1, 0, '0, 0, 0);
        tick();
        chk("sync_issue", 80'(bus.instr_port[79:72]), 80'hFF);
        drive(1, 0, '0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 0, '0, 0, 1);
        tick();
        chk("rst_sync_count", 80'(bus.fifo_count), 80'h0);
        chk("rst_sync_en", 80'(bus.instr_enable), 80'h0);
        chk("rst_sync_ready", 80'(bus.host_ready), 80'h1);
        rst = 1'b1;
        drive(1, 0, '0, 0, 1);
        tick();
        chk("rst_no_sync_done", 80'(bus.sync_done), 80'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                  {($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 254)),
                   32'($urandom), 24'($urandom), 16'($urandom)},
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/tpu_instr_scheduler.md
TPU_INSTR_SCHEDULER -- requirements
Module: tpu_instr_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter SYNC_OPCODE, default 8'hFF, opcode marking a synchronize instruction.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 SHALL have port enable  input  1  issue permission; 0 blocks new issues only.
REQ-006 SHALL have port host_instr  input  instr_type (80: opcode 8, length 32, buffer_addr 24, acc_addr 16)  instruction from host.
REQ-007 SHALL have port host_valid  input  1  host_instr valid this cycle.
REQ-008 SHALL have port host_ready  output  1  FIFO not full; push accepted when host_valid && host_ready.
REQ-009 SHALL have port instr_port  output  instr_type  instruction to tpu_core, registered.
REQ-010 SHALL have port instr_enable  output  1  one-cycle issue strobe to tpu_core, registered.
REQ-011 SHALL have port busy  input  1  tpu_core busy.
REQ-012 SHALL have port synchronize  input  1  tpu_core synchronize pulse.
REQ-013 SHALL have port sync_done  output  1  one-cycle pulse when a synchronize instruction retires.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL implement FSM states IDLE, HOLD, SYNC_WAIT.
REQ-016 IDLE: if enable && !empty && !busy, SHALL pop the head entry, drive it on instr_port with instr_enable=1 next cycle, and go to HOLD (SYNC_WAIT if head opcode == SYNC_OPCODE).
REQ-017 HOLD SHALL last exactly one cycle (busy settle), then go to IDLE; maximum issue rate is one instruction per 2 cycles.
REQ-018 SYNC_WAIT SHALL issue nothing until synchronize=1, then pulse sync_done for one cycle the next cycle and return to IDLE.
REQ-019 instr_enable SHALL be 1 for exactly one cycle per issue; instr_port SHALL hold the last issued instruction otherwise.
REQ-020 Issue latency SHALL be one cycle from the IDLE decision cycle to instr_enable high; an entry pushed in cycle N is eligible for issue no earlier than cycle N+1.
REQ-021 FIFO SHALL be first-in first-out; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 host_ready SHALL equal (fifo_count != FIFO_DEPTH), combinational from registered count; push while full SHALL be ignored even if a pop occurs that cycle.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; a pop only takes an entry present before the cycle (no same-cycle bypass).
REQ-024 enable=0 SHALL block new issues in IDLE but SHALL NOT abort HOLD or SYNC_WAIT; pushes are still accepted.

Reset
REQ-025 rst=0 at a clock edge SHALL flush FIFO (fifo_count=0), set state IDLE, instr_enable=0, instr_port=all zeros, sync_done=0; host_ready=1 from the first cycle after reset.
REQ-026 Reset mid-operation (including SYNC_WAIT) SHALL discard all queued entries and any pending sync without emitting sync_done.

Configuration
REQ-027 Macro TPU_SCHED_PERF_EN defined: SHALL add outputs issued_count (32) and stall_count (32); issued_count increments per instr_enable, stall_count per cycle in IDLE with !empty && (busy || !enable); both saturate at all-ones and reset to 0.
REQ-028 Macro undefined: SHALL omit those ports and counters; all other behaviour identical.

Verification
REQ-029 Reset then push 3 instrs (opcode 8'h09, 8'h21, 8'h99), busy=0, enable=1 -> instr_enable pulses in 3 cycles spaced 2 apart, in push order, fifo_count returns to 0.
REQ-030 Push FIFO_DEPTH=16 instrs with enable=0 -> host_ready=0 at count 16; 17th push dropped; after enable=1 exactly 16 issues.
REQ-031 Queue 8'h21 with busy=1 for 5 cycles -> no instr_enable while busy; issue one cycle after busy falls; stall_count=5 when PERF_EN defined.
REQ-032 Issue 8'hFF then queue 8'h09 -> 8'h09 not issued until synchronize pulses; sync_done high exactly one cycle after synchronize; then 8'h09 issues.
REQ-033 Reset asserted during SYNC_WAIT with 4 queued -> fifo_count=0, instr_enable=0, no sync_done, host_ready=1 next cycle.
REQ-034 Push and pop in the same cycle at count 16, then push 20 more over time -> pointers wrap, FIFO order preserved, no lost or duplicated entries.
